// File: rtl/player_pkg.sv
// player_pkg: button indices, FSM states, default screen geometry and the clamped step helper shared by player_motion
package player_pkg;
  localparam int BTN_UP = 0;
  localparam int BTN_DOWN = 1;
  localparam int BTN_LEFT = 2;
  localparam int BTN_RIGHT = 3;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int OBJ_SIZE = 32;
  typedef enum logic [1:0] {IDLE, FIRST, HOLD, REPEAT} motion_state_t;
  function automatic logic signed [1:0] axis_dir(input logic neg, input logic pos);
    return (pos && !neg) ? 2'sd1 : (neg && !pos) ? -2'sd1 : 2'sd0;
  endfunction
  function automatic logic [31:0] clamp_step(input logic [31:0] pos, input logic signed [1:0] dir, input int stride, input int hi);
    logic signed [32:0] n;
    n = $signed({1'b0, pos}) + 33'(dir) * 33'(stride);
    return (n < 0) ? 32'd0 : (n > 33'(hi)) ? 32'(hi) : n[31:0];
  endfunction
endpackage

// File: rtl/player_motion_if.sv
// player_motion_if: raw buttons and frame tick in, sprite position/geometry and moved pulse out
interface player_motion_if;
  logic [3:0] btns;
  logic frame_tick;
  logic [31:0] player_hStartPos;
  logic [31:0] player_vStartPos;
  logic [31:0] player_objWidth;
  logic [31:0] player_objHeight;
  logic [31:0] player_hOffset;
  logic [31:0] player_vOffset;
  logic moved;
  modport master (
    output btns, frame_tick,
    input player_hStartPos, player_vStartPos, player_objWidth, player_objHeight, player_hOffset, player_vOffset, moved
  );
  modport slave (
    input btns, frame_tick,
    output player_hStartPos, player_vStartPos, player_objWidth, player_objHeight, player_hOffset, player_vOffset, moved
  );
endinterface

// File: rtl/player_motion_btn_debounce.sv
// btn_debounce: 2-FF synchroniser plus stability counter for one button; ports clk, rst, raw in, db out
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic db
);
  localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      cnt <= '0;
      db <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] == db) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        db <= sync[1];
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/player_motion.sv
// player_motion: debounced press/hold/auto-repeat sprite mover, frame-tick stepped and clamped; ports clk, rst, bus (slave)
module player_motion
  import player_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int STEP = 4,
  parameter int HOLD_FRAMES = 15,
  parameter int H_MAX = SCREEN_W,
  parameter int V_MAX = SCREEN_H,
  parameter int OBJ_W = OBJ_SIZE,
  parameter int OBJ_H = OBJ_SIZE,
  parameter int H_INIT = 304,
  parameter int V_INIT = 224
) (
  input logic clk,
  input logic rst,
  player_motion_if.slave bus
);
  localparam int HCW = $clog2(HOLD_FRAMES) + 1;
  logic [3:0] db;
  motion_state_t state, state_nx;
  logic [3:0] db_last, db_last_nx;
  logic [HCW-1:0] hold_cnt, hold_cnt_nx;
  logic step;
  logic [31:0] h_pos, v_pos, h_nx, v_nx;
  logic moved;
  for (genvar b = 0; b < 4; b++) begin : g_db
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk(clk),
      .rst(rst),
      .raw(bus.btns[b]),
      .db(db[b])
    );
  end
  always_comb begin
    state_nx = state;
    db_last_nx = db_last;
    hold_cnt_nx = hold_cnt;
    step = 1'b0;
    unique case (state)
      IDLE: begin
        if (db != '0) begin
          state_nx = FIRST;
          db_last_nx = db;
        end
      end
      FIRST: begin
        if (db == '0) begin
          state_nx = IDLE;
        end else if (bus.frame_tick) begin
          step = 1'b1;
          state_nx = HOLD;
          hold_cnt_nx = '0;
        end
      end
      HOLD: begin
        if (db == '0) begin
          state_nx = IDLE;
        end else if (db != db_last) begin
          state_nx = FIRST;
          db_last_nx = db;
        end else if (bus.frame_tick) begin
          hold_cnt_nx = hold_cnt + 1'b1;
          if (int'(hold_cnt) + 1 >= HOLD_FRAMES - 1) state_nx = REPEAT;
        end
      end
      REPEAT: begin
        // a tick coinciding with a combination change still steps here; FIRST never sees it
        step = bus.frame_tick;
        if (db == '0) begin
          state_nx = IDLE;
        end else if (db != db_last) begin
          state_nx = FIRST;
          db_last_nx = db;
        end
      end
    endcase
  end
  assign h_nx = clamp_step(h_pos, axis_dir(db[BTN_LEFT], db[BTN_RIGHT]), STEP, H_MAX - OBJ_W);
  assign v_nx = clamp_step(v_pos, axis_dir(db[BTN_UP], db[BTN_DOWN]), STEP, V_MAX - OBJ_H);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      db_last <= '0;
      hold_cnt <= '0;
      h_pos <= 32'(H_INIT);
      v_pos <= 32'(V_INIT);
      moved <= 1'b0;
    end else begin
      state <= state_nx;
      db_last <= db_last_nx;
      hold_cnt <= hold_cnt_nx;
      moved <= step && (h_nx != h_pos || v_nx != v_pos);
      if (step) begin
        h_pos <= h_nx;
        v_pos <= v_nx;
      end
    end
  end
  assign bus.player_hStartPos = h_pos;
  assign bus.player_vStartPos = v_pos;
  assign bus.player_objWidth = 32'(OBJ_W);
  assign bus.player_objHeight = 32'(OBJ_H);
  assign bus.player_hOffset = 32'd0;
  assign bus.player_vOffset = 32'd0;
  assign bus.moved = moved;
endmodule
